// File: rtl/instr_fetch.sv
// instr_fetch: PC-driven instruction fetch with a 2-entry {pc, word} FIFO, redirect/flush and halt at PC 0.
// Optional waitrequest stall counter is built when INSTR_FETCH_STALL_CNT_EN is defined.
module instr_fetch #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [31:0] avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic [31:0] mem_in,
    output logic        fetch,
    output logic [31:0] pc_out,
    input  logic        instr_ack,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        halted,
    output logic [31:0] stall_cycles
);
    typedef enum logic [1:0] {IDLE, REQ, DRAIN, HALT} state_t;
    state_t      state_q;
    logic [31:0] npc_q, addr_q;
    logic        read_q, halted_q, rd_q;
    logic [1:0]  cnt_q;
    logic [31:0] pc_q [2];
    logic [31:0] word_q [2];
    logic        accept, pending, pop, push, b2b, wr_idx;
    logic [1:0]  cnt_pop, cnt_after;
    logic [31:0] npc_inc, rpc;
    assign accept    = read_q && !avm_waitrequest;
    assign pending   = read_q && avm_waitrequest;
    assign pop       = instr_ack && fetch && !redirect;
    assign push      = accept && state_q == REQ && !redirect;
    assign cnt_pop   = cnt_q - {1'b0, pop};
    assign cnt_after = cnt_pop + {1'b0, push};
    assign npc_inc   = npc_q + 32'd4;
    assign rpc       = redirect_pc & ~32'h3;
    assign wr_idx    = rd_q ^ cnt_q[0];
    // Back-to-back read only when the FIFO still has room after this cycle's push/pop.
    assign b2b       = !cnt_after[1] && npc_inc != '0;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            npc_q    <= RESET_VECTOR;
            addr_q   <= RESET_VECTOR;
            read_q   <= 1'b0;
            halted_q <= 1'b0;
            rd_q     <= 1'b0;
            cnt_q    <= '0;
            pc_q     <= '{default: '0};
            word_q   <= '{default: '0};
        end else if (redirect) begin
            // A stalled request must stay on the bus, so it is drained and its data dropped.
            cnt_q    <= '0;
            npc_q    <= rpc;
            read_q   <= pending;
            state_q  <= pending ? DRAIN : (rpc == '0 ? HALT : IDLE);
            halted_q <= !pending && rpc == '0;
        end else begin
            if (push) begin
                pc_q[wr_idx]   <= addr_q;
                word_q[wr_idx] <= avm_readdata;
            end
            rd_q  <= rd_q ^ pop;
            cnt_q <= cnt_after;
            case (state_q)
                IDLE: begin
                    if (npc_q == '0) begin
                        state_q  <= HALT;
                        halted_q <= 1'b1;
                    end else if (!cnt_pop[1]) begin
                        state_q <= REQ;
                        read_q  <= 1'b1;
                        addr_q  <= npc_q;
                    end
                end
                REQ: begin
                    if (accept) begin
                        npc_q <= npc_inc;
                        if (b2b) begin
                            addr_q <= npc_inc;
                        end else begin
                            state_q <= IDLE;
                            read_q  <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    if (accept) begin
                        state_q <= IDLE;
                        read_q  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
    assign avm_address = addr_q;
    assign avm_read    = read_q;
    assign fetch       = cnt_q != '0;
    assign mem_in      = word_q[rd_q];
    assign pc_out      = pc_q[rd_q];
    assign halted      = halted_q;
`ifdef INSTR_FETCH_STALL_CNT_EN
    logic [31:0] stall_q;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) stall_q <= '0;
        else if (pending && stall_q != 32'hFFFF_FFFF) stall_q <= stall_q + 32'd1;
    end
    assign stall_cycles = stall_q;
`else
    assign stall_cycles = '0;
`endif
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed vector table, hand sequences and a randomized run against a queue-based fetch model.
module tb_instr_fetch;
    localparam logic [31:0] RV = 32'hBFC0_0000;
`ifdef INSTR_FETCH_STALL_CNT_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif
    logic        clk = 1'b0, reset_n = 1'b0;
    logic [31:0] avm_address, avm_readdata = '0, mem_in, pc_out, redirect_pc = '0, stall_cycles;
    logic        avm_read, avm_waitrequest = 1'b0, fetch, instr_ack = 1'b0, redirect = 1'b0, halted;
    int tests = 0, fails = 0;

    always #5 clk = ~clk;

    instr_fetch dut (
        .clk(clk), .reset_n(reset_n), .avm_address(avm_address), .avm_read(avm_read),
        .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata), .mem_in(mem_in),
        .fetch(fetch), .pc_out(pc_out), .instr_ack(instr_ack), .redirect(redirect),
        .redirect_pc(redirect_pc), .halted(halted), .stall_cycles(stall_cycles)
    );

    typedef struct {
        bit w, ack, rd;
        logic [31:0] rpc;
        bit e_read;
        logic [31:0] e_addr;
        bit e_fetch;
        logic [31:0] e_pc;
        bit e_halt;
    } vec_t;
    vec_t tbl [18];

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h2408_0005;
    endfunction

    function automatic vec_t v(input bit w, ack, rd, input logic [31:0] rpc, input bit er,
                               input logic [31:0] ea, input bit ef, input logic [31:0] ep, input bit eh);
        return '{w, ack, rd, rpc, er, ea, ef, ep, eh};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input bit w, input bit ack, input bit rd, input logic [31:0] rpc);
        avm_waitrequest = w;
        instr_ack = ack;
        redirect = rd;
        redirect_pc = rpc;
        avm_readdata = memf(avm_address);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset_n = 1'b0;
        drive(0, 0, 0, '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Reference model: FIFO as queues, one outstanding request, drop flag for flushed reads.
    logic [31:0] q_pc[$], q_w[$];
    logic [31:0] m_npc, m_addr, m_stall;
    bit          m_pend, m_drop, m_halt;

    task automatic model_init;
        q_pc.delete(); q_w.delete();
        m_npc = RV; m_addr = RV; m_stall = '0;
        m_pend = 0; m_drop = 0; m_halt = 0;
    endtask

    task automatic model_step(input bit w, input bit ack, input bit rd, input logic [31:0] rpc,
                              input logic [31:0] data);
        bit acc = m_pend && !w;
        if (STALL_EN && m_pend && w && m_stall != 32'hFFFF_FFFF) m_stall++;
        if (rd) begin
            q_pc.delete(); q_w.delete();
            m_npc = rpc & ~32'h3;
            if (m_pend && w) m_drop = 1;
            else begin
                m_pend = 0; m_drop = 0; m_halt = (m_npc == 0);
            end
        end else begin
            if (ack && q_pc.size() != 0) begin
                void'(q_pc.pop_front()); void'(q_w.pop_front());
            end
            if (acc) begin
                if (m_drop) begin
                    m_drop = 0; m_pend = 0;
                end else begin
                    q_pc.push_back(m_addr); q_w.push_back(data);
                    m_npc = m_npc + 4;
                    if (q_pc.size() < 2 && m_npc != 0) m_addr = m_npc;
                    else m_pend = 0;
                end
            end else if (!m_pend && !m_halt) begin
                if (m_npc == 0) m_halt = 1;
                else if (q_pc.size() < 2) begin
                    m_pend = 1; m_addr = m_npc;
                end
            end
        end
    endtask

    initial begin
        tbl[0]  = v(0, 1, 0, '0, 0, '0, 0, '0, 0);
        tbl[1]  = v(0, 1, 0, '0, 1, RV, 0, '0, 0);
        tbl[2]  = v(0, 1, 0, '0, 1, RV + 4, 1, RV, 0);
        tbl[3]  = v(0, 1, 0, '0, 1, RV + 8, 1, RV + 4, 0);
        tbl[4]  = v(0, 0, 0, '0, 1, RV + 12, 1, RV + 8, 0);
        tbl[5]  = v(0, 0, 0, '0, 0, '0, 1, RV + 8, 0);
        tbl[6]  = v(0, 1, 0, '0, 0, '0, 1, RV + 8, 0);
        tbl[7]  = v(1, 0, 0, '0, 1, RV + 16, 1, RV + 12, 0);
        tbl[8]  = v(0, 0, 0, '0, 1, RV + 16, 1, RV + 12, 0);
        tbl[9]  = v(0, 1, 1, '0, 0, '0, 1, RV + 12, 0);
        tbl[10] = v(0, 0, 0, '0, 0, '0, 0, '0, 1);
        tbl[11] = v(0, 0, 1, 32'h40, 0, '0, 0, '0, 1);
        tbl[12] = v(0, 0, 0, '0, 0, '0, 0, '0, 0);
        tbl[13] = v(0, 0, 0, '0, 1, 32'h40, 0, '0, 0);
        tbl[14] = v(0, 1, 1, 32'h1003, 1, 32'h44, 1, 32'h40, 0);
        tbl[15] = v(0, 0, 0, '0, 0, '0, 0, '0, 0);
        tbl[16] = v(0, 0, 0, '0, 1, 32'h1000, 0, '0, 0);
        tbl[17] = v(0, 0, 0, '0, 1, 32'h1004, 1, 32'h1000, 0);

        do_reset();
        for (int i = 0; i < 18; i++) begin
            chk($sformatf("tbl%0d_read", i), 32'(avm_read), 32'(tbl[i].e_read));
            if (tbl[i].e_read) chk($sformatf("tbl%0d_addr", i), avm_address, tbl[i].e_addr);
            chk($sformatf("tbl%0d_fetch", i), 32'(fetch), 32'(tbl[i].e_fetch));
            if (tbl[i].e_fetch) begin
                chk($sformatf("tbl%0d_pc", i), pc_out, tbl[i].e_pc);
                chk($sformatf("tbl%0d_mem", i), mem_in, memf(tbl[i].e_pc));
            end
            chk($sformatf("tbl%0d_halted", i), 32'(halted), 32'(tbl[i].e_halt));
            drive(tbl[i].w, tbl[i].ack, tbl[i].rd, tbl[i].rpc);
            tick();
        end

        // Reset values, then a 3-cycle stall on the first read.
        do_reset();
        chk("rst_read", 32'(avm_read), 0);
        chk("rst_addr", avm_address, RV);
        chk("rst_fetch", 32'(fetch), 0);
        chk("rst_mem", mem_in, 0);
        chk("rst_pc", pc_out, 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_stall", stall_cycles, 0);
        avm_waitrequest = 1'b1;
        avm_readdata = 32'h2408_0005;
        tick();
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("stall%0d_read", k), 32'(avm_read), 1);
            chk($sformatf("stall%0d_addr", k), avm_address, RV);
            if (k == 3) avm_waitrequest = 1'b0;
            tick();
        end
        chk("stall_fetch", 32'(fetch), 1);
        chk("stall_mem", mem_in, 32'h2408_0005);
        chk("stall_pc", pc_out, RV);
        chk("stall_cnt", stall_cycles, STALL_EN ? 32'd3 : 32'd0);

        // Redirect during a stalled read, then reset during another stalled read.
        do_reset();
        avm_waitrequest = 1'b1;
        tick();
        redirect = 1'b1;
        redirect_pc = 32'h1000;
        tick();
        redirect = 1'b0;
        chk("drain_read", 32'(avm_read), 1);
        chk("drain_addr", avm_address, RV);
        chk("drain_fetch", 32'(fetch), 0);
        tick();
        chk("drain_hold_read", 32'(avm_read), 1);
        chk("drain_hold_addr", avm_address, RV);
        avm_waitrequest = 1'b0;
        avm_readdata = memf(RV);
        tick();
        chk("drain_done_read", 32'(avm_read), 0);
        chk("drain_discard", 32'(fetch), 0);
        tick();
        chk("redir_read", 32'(avm_read), 1);
        chk("redir_addr", avm_address, 32'h1000);
        chk("redir_empty", 32'(fetch), 0);
        avm_readdata = memf(32'h1000);
        tick();
        chk("redir_fetch", 32'(fetch), 1);
        chk("redir_pc", pc_out, 32'h1000);
        chk("redir_mem", mem_in, memf(32'h1000));
        avm_waitrequest = 1'b1;
        tick();
        chk("pre_rst_read", 32'(avm_read), 1);
        chk("pre_rst_addr", avm_address, 32'h1004);
        #2 reset_n = 1'b0;
        #1;
        chk("async_read", 32'(avm_read), 0);
        chk("async_fetch", 32'(fetch), 0);
        chk("async_addr", avm_address, RV);
        chk("async_pc", pc_out, 0);
        @(negedge clk);
        reset_n = 1'b1;
        avm_waitrequest = 1'b0;
        tick();
        chk("restart_read", 32'(avm_read), 1);
        chk("restart_addr", avm_address, RV);

        // Randomized run against the model.
        do_reset();
        model_init();
        for (int c = 0; c < 3000; c++) begin
            bit w, ack, rd;
            logic [31:0] rpc;
            chk("rnd_read", 32'(avm_read), 32'(m_pend));
            if (m_pend) chk("rnd_addr", avm_address, m_addr);
            chk("rnd_fetch", 32'(fetch), 32'(q_pc.size() != 0));
            if (q_pc.size() != 0) begin
                chk("rnd_pc", pc_out, q_pc[0]);
                chk("rnd_mem", mem_in, q_w[0]);
            end
            chk("rnd_halted", 32'(halted), 32'(m_halt));
            chk("rnd_stall", stall_cycles, m_stall);
            w = ($urandom % 4) == 0;
            ack = ($urandom % 2) == 0;
            rd = ($urandom % 25) == 0;
            rpc = ($urandom % 5 == 0) ? 32'($urandom % 4) : 32'($urandom_range(1, 255) * 4 + $urandom % 4);
            drive(w, ack, rd, rpc);
            model_step(w, ack, rd, rpc, avm_readdata);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
